iob_prio_dec: RTL and testbench
===============================

IOB_PRIO_DEC -- requirements
Module: iob_prio_dec

Interface
REQ-001 SHALL have parameter W, default 8, mask width in bits (W >= 1).
REQ-002 SHALL have parameter IW, default $clog2(W+1), index width; all index ports are IW bits.
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cke_i  input  1  clock enable; when low, all state is frozen.
REQ-006 SHALL have port idx_valid_i  input  1  index beat offered.
REQ-007 SHALL have port idx_i  input  IW  encoded bit position; value W means "no bit".
REQ-008 SHALL have port idx_last_i  input  1  final beat of a mask.
REQ-009 SHALL have port idx_ready_o  output  1  index beat accepted when high with valid.
REQ-010 SHALL have port mask_valid_o  output  1  assembled mask available.
REQ-011 SHALL have port mask_o  output  W  assembled one-hot-OR mask.
REQ-012 SHALL have port mask_ready_i  input  1  consumer takes mask.
REQ-013 SHALL have port err_o  output  1  sticky out-of-range index flag.
REQ-014 SHALL have port err_clr_i  input  1  clears err_o.

Function
REQ-015 SHALL implement FSM states ACCUM and HOLD.
REQ-016 SHALL make an input transfer occur on a cycle with idx_valid_i & idx_ready_o & cke_i.
REQ-017 SHALL drive idx_ready_o = 1 in ACCUM and 0 in HOLD.
REQ-018 SHALL OR a one-hot bit (1 << idx_i) into the accumulator on each transfer with idx_i < W.
REQ-019 SHALL add no bit for idx_i == W, but still honour idx_last_i on that beat.
REQ-020 SHALL treat idx_i > W as an error: add no bit, set err_o the next cycle, and still honour idx_last_i.
REQ-021 SHALL, on a transfer with idx_last_i = 1, load mask_o with (accumulator | that beat's bit), clear the accumulator, assert mask_valid_o the next cycle, and go to HOLD.
REQ-022 SHALL hold mask_o and mask_valid_o stable in HOLD until mask_valid_o & mask_ready_i, then deassert mask_valid_o and return to ACCUM the next cycle.
REQ-023 SHALL have a latency of one cycle from the last-beat transfer to mask_valid_o.
REQ-024 SHALL NOT accept input in the cycle the mask is consumed (no bypass); the minimum mask period is 2 cycles.
REQ-025 SHALL make a single beat with idx_last_i = 1 and idx_i == W produce mask_o = 0 with mask_valid_o = 1.
REQ-026 SHALL give set priority to err_o: an error and err_clr_i in the same cycle leave err_o = 1.
REQ-027 SHALL ignore repeated indices (OR semantics, idempotent).
REQ-028 SHALL leave mask_o unspecified-but-stable (retains the last value) while mask_valid_o = 0.

Reset
REQ-029 SHALL, while arst_n_i = 0, asynchronously force state ACCUM, accumulator 0, mask_o 0, mask_valid_o 0, and err_o 0.
REQ-030 SHALL drive idx_ready_o = 1 in the first cycle after reset release.
REQ-031 SHALL discard a partially accumulated mask, or a held mask, on reset mid-operation.

Structure
REQ-032 SHALL place state encodings (ACCUM, HOLD) and the default W in a shared package/include for iob_prio_dec.
REQ-033 SHALL instantiate one sub-module, iob_prio_dec_onehot: combinational idx to one-hot with an out-of-range flag.
REQ-034 SHALL register all outputs except idx_ready_o, which is decoded directly from state.

Verification
REQ-035 SHALL cover, with W=8: beats 3, 5, 3(last) -> mask_o = 8'h28 and mask_valid_o one cycle after the last beat.
REQ-036 SHALL cover, with W=8: a single beat 8(last) -> mask_o = 8'h00, mask_valid_o = 1, err_o = 0.
REQ-037 SHALL cover, with W=8: beats 2, 12(last) -> mask_o = 8'h04 and err_o = 1; then err_clr_i pulse -> err_o = 0.
REQ-038 SHALL cover: mask_ready_i held low 5 cycles -> idx_ready_o = 0 and mask_o stable throughout; after the ready pulse, idx_ready_o returns to 1 the next cycle.
REQ-039 SHALL cover: arst_n_i pulsed low after beats 1, 2 (no last), then beat 7(last) -> mask_o = 8'h80.
REQ-040 SHALL cover: cke_i = 0 with idx_valid_i = 1 for 3 cycles -> no transfer and no state change.

Source files
------------

// File: rtl/iob_prio_dec_pkg.sv
// Shared definitions for the index-to-mask priority decoder.
// State encodings and the default mask width live here.
package iob_prio_dec_pkg;

  localparam int unsigned W_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/iob_prio_dec_if.sv
// Handshake bundle for the priority decoder: index beats in, masks out.
// master drives beats and takes masks; slave is the decoder side.
interface iob_prio_dec_if
  import iob_prio_dec_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int IW = $clog2(W + 1)
);

  logic          cke;
  logic          idx_valid;
  logic [IW-1:0] idx;
  logic          idx_last;
  logic          idx_ready;
  logic          mask_valid;
  logic [W-1:0]  mask;
  logic          mask_ready;
  logic          err;
  logic          err_clr;

  modport master (
    output cke, idx_valid, idx, idx_last, mask_ready, err_clr,
    input  idx_ready, mask_valid, mask, err
  );

  modport slave (
    input  cke, idx_valid, idx, idx_last, mask_ready, err_clr,
    output idx_ready, mask_valid, mask, err
  );

endinterface

// File: rtl/iob_prio_dec_onehot.sv
// Combinational index to one-hot decode.
// Index W decodes to no bit; anything above W is flagged out of range.
module iob_prio_dec_onehot
  import iob_prio_dec_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int IW = $clog2(W + 1)
) (
  input  logic [IW-1:0] idx_i,
  output logic [W-1:0]  bit_o,
  output logic          oor_o
);

  always_comb begin
    bit_o = '0;
    for (int i = 0; i < W; i++) begin
      bit_o[i] = (idx_i == IW'(i));
    end
  end

  assign oor_o = (idx_i > IW'(W));

endmodule

// File: rtl/iob_prio_dec.sv
// Accumulates encoded index beats into an OR mask and hands the
// mask off with a valid/ready handshake; sticky out-of-range flag.
module iob_prio_dec
  import iob_prio_dec_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int IW = $clog2(W + 1)
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          cke_i,
  input  logic          idx_valid_i,
  input  logic [IW-1:0] idx_i,
  input  logic          idx_last_i,
  output logic          idx_ready_o,
  output logic          mask_valid_o,
  output logic [W-1:0]  mask_o,
  input  logic          mask_ready_i,
  output logic          err_o,
  input  logic          err_clr_i
);

  state_e         state_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   acc_d;
  logic [W-1:0]   mask_q;
  logic           mval_q;
  logic           err_q;
  logic [W-1:0]   beat_bit;
  logic           beat_oor;
  logic           xfer;

  iob_prio_dec_onehot #(
    .W  (W),
    .IW (IW)
  ) u_onehot (
    .idx_i (idx_i),
    .bit_o (beat_bit),
    .oor_o (beat_oor)
  );

  assign idx_ready_o = (state_q == ACCUM);
  assign xfer        = idx_valid_i & idx_ready_o & cke_i;
  assign acc_d       = acc_q | beat_bit;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      mask_q  <= '0;
      mval_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (cke_i) begin
      // A new error wins over a clear in the same cycle
      if (xfer && beat_oor) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
      unique case (state_q)
        ACCUM: begin
          if (xfer) begin
            if (idx_last_i) begin
              mask_q  <= acc_d;
              acc_q   <= '0;
              mval_q  <= 1'b1;
              state_q <= HOLD;
            end else begin
              acc_q <= acc_d;
            end
          end
        end
        HOLD: begin
          if (mask_ready_i) begin
            mval_q  <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign mask_valid_o = mval_q;
  assign mask_o       = mask_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_iob_prio_dec.sv
// Directed bench for iob_prio_dec at W=8.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_iob_prio_dec;

  localparam int W  = 8;
  localparam int IW = 4;

  logic clk;
  logic arst_n;
  int   n_chk;
  int   n_fail;

  iob_prio_dec_if #(.W(W), .IW(IW)) bus ();

  iob_prio_dec #(.W(W), .IW(IW)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .cke_i        (bus.cke),
    .idx_valid_i  (bus.idx_valid),
    .idx_i        (bus.idx),
    .idx_last_i   (bus.idx_last),
    .idx_ready_o  (bus.idx_ready),
    .mask_valid_o (bus.mask_valid),
    .mask_o       (bus.mask),
    .mask_ready_i (bus.mask_ready),
    .err_o        (bus.err),
    .err_clr_i    (bus.err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [IW-1:0] idx, input logic last);
    bus.idx_valid = 1'b1;
    bus.idx       = idx;
    bus.idx_last  = last;
    step();
    bus.idx_valid = 1'b0;
    bus.idx_last  = 1'b0;
  endtask

  task automatic consume();
    bus.mask_ready = 1'b1;
    step();
    bus.mask_ready = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #3;
    n_chk++; if (bus.mask_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mval got %b want 0", bus.mask_valid); end
    n_chk++; if (bus.mask !== 8'h00) begin n_fail++; $display("FAIL rst_mask got %h want 00", bus.mask); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", bus.err); end
    step();
    arst_n = 1'b1;
    step();
    n_chk++; if (bus.idx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.idx_ready); end
  endtask

  task automatic test_basic();
    beat(4'd3, 1'b0);
    beat(4'd5, 1'b0);
    n_chk++; if (bus.mask_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_mval got %b want 0", bus.mask_valid); end
    beat(4'd3, 1'b1);
    n_chk++; if (bus.mask_valid !== 1'b1) begin n_fail++; $display("FAIL basic_mval got %b want 1", bus.mask_valid); end
    n_chk++; if (bus.mask !== 8'h28) begin n_fail++; $display("FAIL basic_mask got %h want 28", bus.mask); end
    n_chk++; if (bus.idx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready got %b want 0", bus.idx_ready); end
    consume();
    n_chk++; if (bus.mask_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done_mval got %b want 0", bus.mask_valid); end
    n_chk++; if (bus.idx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_done_ready got %b want 1", bus.idx_ready); end
    n_chk++; if (bus.mask !== 8'h28) begin n_fail++; $display("FAIL basic_retain got %h want 28", bus.mask); end
  endtask

  task automatic test_empty();
    beat(4'd8, 1'b1);
    n_chk++; if (bus.mask_valid !== 1'b1) begin n_fail++; $display("FAIL empty_mval got %b want 1", bus.mask_valid); end
    n_chk++; if (bus.mask !== 8'h00) begin n_fail++; $display("FAIL empty_mask got %h want 00", bus.mask); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL empty_err got %b want 0", bus.err); end
    consume();
  endtask

  task automatic test_err();
    beat(4'd2, 1'b0);
    beat(4'd12, 1'b1);
    n_chk++; if (bus.mask_valid !== 1'b1) begin n_fail++; $display("FAIL err_mval got %b want 1", bus.mask_valid); end
    n_chk++; if (bus.mask !== 8'h04) begin n_fail++; $display("FAIL err_mask got %h want 04", bus.mask); end
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", bus.err); end
    consume();
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", bus.err); end
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b want 0", bus.err); end
    // error and clear together: set wins
    bus.err_clr = 1'b1;
    beat(4'd9, 1'b1);
    bus.err_clr = 1'b0;
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_prio got %b want 1", bus.err); end
    n_chk++; if (bus.mask !== 8'h00) begin n_fail++; $display("FAIL err_prio_mask got %h want 00", bus.mask); end
    consume();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
  endtask

  task automatic test_hold();
    beat(4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus.idx_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d] got %b want 0", i, bus.idx_ready); end
      n_chk++; if (bus.mask !== 8'h02) begin n_fail++; $display("FAIL hold_mask[%0d] got %h want 02", i, bus.mask); end
      n_chk++; if (bus.mask_valid !== 1'b1) begin n_fail++; $display("FAIL hold_mval[%0d] got %b want 1", i, bus.mask_valid); end
      step();
    end
    consume();
    n_chk++; if (bus.idx_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release got %b want 1", bus.idx_ready); end
  endtask

  task automatic test_back_to_back();
    beat(4'd0, 1'b1);
    // beat offered in the consume cycle must not be taken
    bus.idx_valid  = 1'b1;
    bus.idx        = 4'd4;
    bus.idx_last   = 1'b1;
    bus.mask_ready = 1'b1;
    step();
    bus.mask_ready = 1'b0;
    n_chk++; if (bus.mask_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_nobypass got %b want 0", bus.mask_valid); end
    n_chk++; if (bus.mask !== 8'h01) begin n_fail++; $display("FAIL b2b_old_mask got %h want 01", bus.mask); end
    step();
    bus.idx_valid = 1'b0;
    bus.idx_last  = 1'b0;
    n_chk++; if (bus.mask_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_mval got %b want 1", bus.mask_valid); end
    n_chk++; if (bus.mask !== 8'h10) begin n_fail++; $display("FAIL b2b_mask got %h want 10", bus.mask); end
    consume();
    beat(4'd6, 1'b0);
    beat(4'd6, 1'b0);
    beat(4'd7, 1'b1);
    n_chk++; if (bus.mask !== 8'hC0) begin n_fail++; $display("FAIL repeat_mask got %h want c0", bus.mask); end
    consume();
  endtask

  task automatic test_reset_mid();
    beat(4'd1, 1'b0);
    beat(4'd2, 1'b0);
    arst_n = 1'b0;
    #3;
    arst_n = 1'b1;
    step();
    beat(4'd7, 1'b1);
    n_chk++; if (bus.mask !== 8'h80) begin n_fail++; $display("FAIL rstmid_mask got %h want 80", bus.mask); end
    n_chk++; if (bus.mask_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_mval got %b want 1", bus.mask_valid); end
    // reset while a mask is held
    arst_n = 1'b0;
    #2;
    n_chk++; if (bus.mask_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_mval got %b want 0", bus.mask_valid); end
    n_chk++; if (bus.mask !== 8'h00) begin n_fail++; $display("FAIL rsthold_mask got %h want 00", bus.mask); end
    n_chk++; if (bus.idx_ready !== 1'b1) begin n_fail++; $display("FAIL rsthold_ready got %b want 1", bus.idx_ready); end
    #1;
    arst_n = 1'b1;
    step();
  endtask

  task automatic test_cke();
    bus.cke       = 1'b0;
    bus.idx_valid = 1'b1;
    bus.idx       = 4'd0;
    bus.idx_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (bus.mask_valid !== 1'b0) begin n_fail++; $display("FAIL cke_mval[%0d] got %b want 0", i, bus.mask_valid); end
      n_chk++; if (bus.idx_ready !== 1'b1) begin n_fail++; $display("FAIL cke_ready[%0d] got %b want 1", i, bus.idx_ready); end
    end
    bus.idx_valid = 1'b0;
    bus.idx_last  = 1'b0;
    bus.cke       = 1'b1;
    beat(4'd6, 1'b1);
    n_chk++; if (bus.mask !== 8'h40) begin n_fail++; $display("FAIL cke_after got %h want 40", bus.mask); end
    // frozen while holding: ready is ignored
    bus.cke = 1'b0;
    consume();
    n_chk++; if (bus.mask_valid !== 1'b1) begin n_fail++; $display("FAIL cke_hold got %b want 1", bus.mask_valid); end
    bus.cke = 1'b1;
    consume();
    n_chk++; if (bus.mask_valid !== 1'b0) begin n_fail++; $display("FAIL cke_resume got %b want 0", bus.mask_valid); end
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    arst_n         = 1'b1;
    bus.cke        = 1'b1;
    bus.idx_valid  = 1'b0;
    bus.idx        = '0;
    bus.idx_last   = 1'b0;
    bus.mask_ready = 1'b0;
    bus.err_clr    = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_empty();
    test_err();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_cke();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
